// File: rtl/mem_stage_if.sv
// Memory stage port bundle: execute-side inputs, SRAM read return, and outputs.
// The mem_excp_adel signal exists only when MEM_ALIGN_CHECK_EN is defined.
interface mem_stage_if #(
    parameter int IN_WD    = 79,
    parameter int OUT_WD   = 70,
    parameter int STALL_WD = 6
);
    logic [STALL_WD-1:0] stall;
    logic [IN_WD-1:0]    ex_to_mem_bus;
    logic [31:0]         data_sram_rdata;
    logic                data_sram_rvalid;
    logic [OUT_WD-1:0]   mem_to_wb_bus;
    logic [37:0]         mem_to_id_fwd;
    logic                stallreq_for_mem;
`ifdef MEM_ALIGN_CHECK_EN
    logic                mem_excp_adel;

    modport master (
        output stall, ex_to_mem_bus, data_sram_rdata, data_sram_rvalid,
        input  mem_to_wb_bus, mem_to_id_fwd, stallreq_for_mem, mem_excp_adel
    );
    modport slave (
        input  stall, ex_to_mem_bus, data_sram_rdata, data_sram_rvalid,
        output mem_to_wb_bus, mem_to_id_fwd, stallreq_for_mem, mem_excp_adel
    );
`else
    modport master (
        output stall, ex_to_mem_bus, data_sram_rdata, data_sram_rvalid,
        input  mem_to_wb_bus, mem_to_id_fwd, stallreq_for_mem
    );
    modport slave (
        input  stall, ex_to_mem_bus, data_sram_rdata, data_sram_rvalid,
        output mem_to_wb_bus, mem_to_id_fwd, stallreq_for_mem
    );
`endif
endinterface

// File: rtl/mem_stage.sv
// MIPS memory-access stage: load wait/capture FSM, lane alignment, WB/ID buses.
// Optional misaligned-load detection is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage #(
    parameter int IN_WD    = 79,
    parameter int OUT_WD   = 70,
    parameter int STALL_WD = 6
) (
    input  logic       clk,
    input  logic       rst,
    mem_stage_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
    } state_t;

    logic [IN_WD-1:0] bus_r;
    state_t           state;
    state_t           state_n;
    logic [31:0]      rbuf;
    logic             capture;

    logic [2:0]  load_op;
    logic [31:0] pc;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;

    logic        is_load_raw;
    logic        is_load;
    logic        adel;
    logic        stallreq;
    logic        rvalid;
    logic        stall_mem;
    logic        stall_wb;
    logic        stall_unused;

    logic [31:0] src;
    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] rf_wdata;
    logic        we_out;

    logic op_lb;
    logic op_lbu;
    logic op_lh;
    logic op_lhu;

    assign stall_mem    = bus.stall[3];
    assign stall_wb     = bus.stall[4];
    assign stall_unused = ^{bus.stall[2:0], bus.stall[STALL_WD-1:5]};
    assign rvalid       = bus.data_sram_rvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_r <= '0;
        end else if (stall_mem && !stall_wb) begin
            bus_r <= '0;
        end else if (!stall_mem) begin
            bus_r <= bus.ex_to_mem_bus;
        end
    end

    assign load_op    = bus_r[78:76];
    assign pc         = bus_r[75:44];
    assign ram_en     = bus_r[43];
    assign ram_wen    = bus_r[42:39];
    assign sel_rf_res = bus_r[38];
    assign rf_we      = bus_r[37];
    assign rf_waddr   = bus_r[36:32];
    assign ex_result  = bus_r[31:0];

    assign op_lb  = (load_op == 3'b001);
    assign op_lbu = (load_op == 3'b010);
    assign op_lh  = (load_op == 3'b011);
    assign op_lhu = (load_op == 3'b100);

    assign is_load_raw = ram_en && (ram_wen == 4'b0000) && sel_rf_res;

`ifdef MEM_ALIGN_CHECK_EN
    // Word-class ops (including the reserved encodings) need both low bits clear.
    logic misalign;
    always_comb begin
        misalign = 1'b0;
        unique case (1'b1)
            op_lb, op_lbu: misalign = 1'b0;
            op_lh, op_lhu: misalign = ex_result[0];
            default:       misalign = |ex_result[1:0];
        endcase
    end
    assign adel              = is_load_raw && misalign;
    assign bus.mem_excp_adel = adel;
`else
    assign adel = 1'b0;
`endif

    assign is_load = is_load_raw && !adel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (is_load && !rvalid) begin
                    state_n = S_WAIT;
                end else if (is_load && rvalid && stall_mem) begin
                    state_n = S_HOLD;
                end
            end
            S_WAIT: begin
                if (rvalid) begin
                    state_n = stall_mem ? S_HOLD : S_IDLE;
                end
            end
            S_HOLD: begin
                if (!stall_mem) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        capture  = 1'b0;
        stallreq = 1'b0;
        unique case (state)
            S_IDLE: begin
                capture  = is_load && rvalid;
                stallreq = is_load && !rvalid;
            end
            S_WAIT: begin
                capture  = rvalid;
                stallreq = is_load && !rvalid;
            end
            S_HOLD: begin
                capture  = 1'b0;
                stallreq = 1'b0;
            end
            default: begin
                capture  = 1'b0;
                stallreq = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rbuf <= '0;
        end else if (capture) begin
            rbuf <= bus.data_sram_rdata;
        end
    end

    // Data returned this cycle wins; otherwise use the word captured earlier.
    assign src      = rvalid ? bus.data_sram_rdata : rbuf;
    assign shifted  = src >> {ex_result[1:0], 3'b000};
    assign byte_sel = shifted[7:0];
    assign half_sel = ex_result[1] ? src[31:16] : src[15:0];

    always_comb begin
        load_data = src;
        unique case (1'b1)
            op_lb:   load_data = {{24{byte_sel[7]}}, byte_sel};
            op_lbu:  load_data = {24'h0, byte_sel};
            op_lh:   load_data = {{16{half_sel[15]}}, half_sel};
            op_lhu:  load_data = {16'h0, half_sel};
            default: load_data = src;
        endcase
    end

    assign rf_wdata = is_load ? load_data : ex_result;
    assign we_out   = rf_we && !adel;

    assign bus.mem_to_wb_bus    = {pc, we_out, rf_waddr, rf_wdata};
    assign bus.mem_to_id_fwd    = {we_out && !stallreq, rf_waddr, rf_wdata};
    assign bus.stallreq_for_mem = stallreq;
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access stage of the 5-stage MIPS pipeline. It sits between the execute stage and write-back.
- Registers the execute-to-memory bus under stall control.
- Waits for load data from the data SRAM using a valid handshake.
- Aligns and extends load data by type and address offset.
- Produces the memory-to-writeback bus and an ID-stage forwarding bus.

Parameters:
IN_WD, 79, width of ex_to_mem_bus
OUT_WD, 70, width of mem_to_wb_bus
STALL_WD, 6, width of stall vector (bit 3 = MEM, bit 4 = WB)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
stall  in  STALL_WD  pipeline stall vector
ex_to_mem_bus  in  IN_WD  [78:76] load_op, [75:44] pc, [43] ram_en, [42:39] ram_wen, [38] sel_rf_res, [37] rf_we, [36:32] rf_waddr, [31:0] ex_result
data_sram_rdata  in  32  SRAM read data
data_sram_rvalid  in  1  read data valid, single-cycle pulse
mem_to_wb_bus  out  OUT_WD  [69:38] pc, [37] rf_we, [36:32] rf_waddr, [31:0] rf_wdata
mem_to_id_fwd  out  38  [37] rf_we, [36:32] rf_waddr, [31:0] rf_wdata
stallreq_for_mem  out  1  request pipeline stall while load data is outstanding

Behaviour:
- Input register bus_r update priority:
  - rst: clear to 0.
  - stall[3]=1 and stall[4]=0: clear to 0 (bubble).
  - stall[3]=0: load ex_to_mem_bus.
  - Otherwise: hold.
- is_load = ram_en & (ram_wen==0) & sel_rf_res. A store (ram_wen!=0) never waits and never writes rf.
- load_op encoding:
  - 000 LW: full word.
  - 001 LB: sign-extend byte at ex_result[1:0].
  - 010 LBU: zero-extend that byte.
  - 011 LH: sign-extend half at ex_result[1].
  - 100 LHU: zero-extend that half.
  - 101..111: treated as LW.
- Little-endian lane select: byte k = rdata[8k+7:8k]; half 0 = [15:0], half 1 = [31:16].
- FSM, state reset to IDLE:
  - IDLE: if is_load and rvalid=0, go to WAIT. If is_load and rvalid=1 in the same cycle, capture rdata into rbuf and go to HOLD when stall[3]=1; otherwise stay in IDLE.
  - WAIT: on rvalid, capture rdata into rbuf and go to HOLD when stall[3]=1, else IDLE. With no rvalid, stay in WAIT.
  - HOLD: data is captured while the pipeline is stalled downstream. Return to IDLE on the first cycle with stall[3]=0.
- rbuf resets to 0. A rvalid pulse arriving in IDLE with no load pending is ignored.
- stallreq_for_mem = is_load & ~rvalid & (state != HOLD). It is combinational and resets low. Load data is usable in the rvalid cycle, so minimum load latency is 0 extra cycles.
- Load data source: rdata when rvalid=1, else rbuf.
- rf_wdata = aligned load data if is_load, else ex_result.
- mem_to_wb_bus and mem_to_id_fwd are combinational from bus_r and the load path. After reset both are all-zero (rf_we=0).
- rst mid-WAIT: state goes to IDLE, bus_r clears, stallreq drops next cycle. A late rvalid is ignored.
- Forwarding bus carries rf_we=0 while stallreq_for_mem=1, so ID never bypasses stale load data.

Optional Feature:
MEM_ALIGN_CHECK_EN
- Defined:
  - Misalignment conditions: LW/LH/LHU with ex_result[0]=1, or LW with ex_result[1]=1.
  - Misaligned access: rf_we is forced to 0 on both output buses and no SRAM wait occurs (state stays IDLE).
  - A 1-bit output port mem_excp_adel is added, asserted combinationally for that instruction.
- Undefined: no check is performed, the port is absent, and the low address bits only select lanes.

Test Plan:
- LB at addr 0x1003, rdata 0x80FF_1234 with rvalid in the same cycle -> rf_wdata 0xFFFF_FF80, rf_we=1, stallreq never high.
- LHU at addr 0x2002, rvalid 3 cycles after entry, rdata 0xBEEF_0001 -> stallreq high for exactly 3 cycles; rf_wdata 0x0000_BEEF in the rvalid cycle.
- Load with rvalid while stall[3]=1, stall[4]=1 held 2 more cycles -> state HOLD; output holds the captured word; advances correctly when stall[3] drops.
- stall[3]=1, stall[4]=0 -> next cycle bus_r=0: mem_to_wb_bus rf_we=0 and pc=0.
- rst asserted in WAIT, then rvalid pulse -> outputs all-zero, stallreq=0, pulse ignored.
- MEM_ALIGN_CHECK_EN defined, LW at 0x3002 -> mem_excp_adel=1, rf_we=0, stallreq=0.
